perturb_arbiter: RTL

//  Shares one pipelined perturb_engine among NUM_REQ crossover units. Round-robin grants one

---
 rtl/ga_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/perturb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared GA datapath types: gene word layout and the owner tag carried alongside
// each gene travelling through the perturb engine.
package ga_pkg;

    localparam int GENE_W    = 32;
    localparam int ALLELE_W  = 8;
    localparam int ALLELES   = GENE_W / ALLELE_W;
    localparam int TAG_IDX_W = 3;  // wide enough for up to 8 requesters

    typedef logic [GENE_W-1:0] gene_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester found scanning
// upward from ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);
    import ga_pkg::*;

    int               j;
    logic [IDX_W-1:0] j_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        j_idx     = '0;
        for (int k = 0; k < N; k++) begin
            j     = (int'(ptr) + k) % N;
            j_idx = IDX_W'(j);
            if (!grant_any && req[j_idx]) begin
                grant_any        = 1'b1;
                grant[j_idx]     = 1'b1;
                grant_idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/perturb_arbiter.sv
// Shares one pipelined perturb engine among NUM_REQ crossover units; an owner-tag
// pipe matched to the engine latency routes each child back to its requester.
module perturb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GENE_W  = 32,
    parameter int ENG_LAT = 2,
    parameter int MAX_OUT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      halt,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*GENE_W-1:0] req_gene,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [GENE_W-1:0]         eng_gene,
    input  logic [GENE_W-1:0]         eng_child,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [GENE_W-1:0]         resp_gene,
    output logic                      busy,
    output logic [15:0]               issued_cnt
);
    import ga_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   out_cnt [NUM_REQ];
    // Stage 0 pairs with the eng_gene register; stages 1..ENG_LAT track the engine.
    tag_t               tag_p   [ENG_LAT+1];
    tag_t               tag_last;
    logic [ENG_LAT:0]   tag_valid;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] dec;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               xfer;
    logic [GENE_W-1:0]  win_gene;

    always_comb begin
        eligible = '0;
        win_gene = '0;
        dec      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT)) && !halt;
            if (grant[i])
                win_gene = req_gene[i*GENE_W +: GENE_W];
            dec[i] = tag_last.valid && (tag_last.idx == TAG_IDX_W'(i));
        end
        tag_valid = '0;
        for (int k = 0; k <= ENG_LAT; k++)
            tag_valid[k] = tag_p[k].valid;
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign req_ready = rst ? '0 : grant;
    assign xfer      = win_any && !rst;
    assign tag_last  = tag_p[ENG_LAT];
    assign busy      = (|tag_valid) || (|resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            eng_gene   <= '0;
            resp_valid <= '0;
            resp_gene  <= '0;
            issued_cnt <= '0;
            for (int k = 0; k <= ENG_LAT; k++)
                tag_p[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                out_cnt[i] <= '0;
        end else begin
            // p0: accept into the engine input register
            eng_gene <= xfer ? win_gene : '0;
            tag_p[0] <= {xfer, TAG_IDX_W'(win_idx)};
            if (xfer) begin
                rr_ptr     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                issued_cnt <= issued_cnt + 16'd1;
            end
            // p1..pN: tags shift in lockstep with the engine, never stalled
            for (int k = 1; k <= ENG_LAT; k++)
                tag_p[k] <= tag_p[k-1];
            // response register
            resp_valid <= dec;
            if (tag_last.valid)
                resp_gene <= eng_child;
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({xfer && grant[i], dec[i]})
                    2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
                    2'b01:   out_cnt[i] <= out_cnt[i] - 1'b1;
                    default: out_cnt[i] <= out_cnt[i];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_chk
        assert property (@(posedge clk) disable iff (rst) !(dec[g] && out_cnt[g] == '0));
        assert property (@(posedge clk) disable iff (rst) out_cnt[g] <= CNT_W'(MAX_OUT));
    end

endmodule
